imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, capacity of the target instruction memory in 32-bit words.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port byte_valid_i  input  1  image byte offered.
REQ-006 SHALL have port byte_data_i  input  8  image byte.
REQ-007 SHALL have port last_i  input  1  qualifies byte_data_i as final byte of the image.
REQ-008 SHALL have port byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en_o  output  1  instruction-memory write strobe.
REQ-010 SHALL have port wr_addr_o  output  32  byte address of the written word.
REQ-011 SHALL have port wr_data_o  output  32  written instruction word.
REQ-012 SHALL have port start_o  output  1  drives the CPU start input; high once the image is loaded.
REQ-013 SHALL have port err_o  output  1  image overflowed DEPTH_WORDS.

Function
REQ-014 SHALL accept a byte only on a cycle where byte_valid_i and byte_ready_o are both high (transfer).
REQ-015 SHALL implement states IDLE, LOAD, WRITE, DONE, ERROR.
REQ-016 SHALL assert byte_ready_o in IDLE and LOAD only; deassert it in WRITE, DONE, ERROR.
REQ-017 SHALL move IDLE->LOAD on the first transfer.
REQ-018 SHALL pack bytes little-endian: transfer k of a word (k=0..3) lands in bits [8k+7:8k].
REQ-019 SHALL enter WRITE the cycle after the 4th transfer of a word, or after a transfer with last_i=1.
REQ-020 SHALL, on last_i with k<3, zero-fill the unreceived upper bytes of that word.
REQ-021 SHALL in WRITE assert wr_en_o for exactly one cycle with wr_addr_o = BASE_ADDR + 4*word_index and wr_data_o = packed word.
REQ-022 SHALL hold wr_en_o low, and wr_addr_o/wr_data_o at their last written values, in every other state.
REQ-023 SHALL increment word_index by 1 after each WRITE; WRITE->LOAD if the word was not last, WRITE->DONE if it was.
REQ-024 SHALL enter ERROR instead of accepting a byte when word_index equals DEPTH_WORDS in LOAD; no write occurs, err_o=1, start_o=0.
REQ-025 SHALL hold start_o=1 in DONE and 0 in all other states; DONE and ERROR exit only via reset.
REQ-026 SHALL ignore last_i when no transfer occurs.
REQ-027 SHALL make write latency exactly 1 cycle from the completing transfer to wr_en_o.

Reset
REQ-028 SHALL on rst_i=1 at a clock edge: state=IDLE, word_index=0, byte count=0, packed word=0.
REQ-029 SHALL drive after reset: byte_ready_o=1, wr_en_o=0, wr_addr_o=BASE_ADDR, wr_data_o=0, start_o=0, err_o=0.
REQ-030 SHALL, on reset mid-load or mid-WRITE, discard the partial word without emitting wr_en_o and deassert start_o on the following cycle.

Structure
REQ-031 SHALL take its state enumeration and the word/byte width constants from the shared CPU package.
REQ-032 SHALL contain one sub-module, byte_packer: a 2-bit byte counter plus 32-bit shift/insert register with clear and zero-fill.
REQ-033 SHALL keep the FSM, address counter and overflow check in imem_loader.

Verification
REQ-034 SHALL cover: bytes 13,00,50,00 then 93,00,A0,00 with last on the final byte -> writes 0x00500013@0x0, 0x00A00093@0x4, start_o=1.
REQ-035 SHALL cover: 5 bytes 11,22,33,44,55 with last on 55 -> writes 0x44332211@0x0, 0x00000055@0x4.
REQ-036 SHALL cover: DEPTH_WORDS=2, 9 bytes offered -> 2 writes, 9th byte not accepted, err_o=1, start_o=0.
REQ-037 SHALL cover: byte_valid_i toggled randomly with gaps -> identical write sequence; byte_ready_o low during every WRITE cycle.
REQ-038 SHALL cover: rst_i pulsed after 2 bytes of a word -> no write, next 4 bytes AA,BB,CC,DD (last) write 0xDDCCBBAA@BASE_ADDR.
REQ-039 SHALL cover: BASE_ADDR=32'h100, one word -> wr_addr_o=0x100; further byte_valid_i in DONE ignored, start_o stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and the loader state encoding.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: inserts each pushed byte at the current lane and
// presents the completed word (upper lanes zero-filled on last) in the same cycle.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] word_o,
  output logic              done_o
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] word_ins;

  always_comb begin
    word_ins = word_q;
    word_ins[{cnt_q, 3'b000} +: BYTE_W] = byte_i;
    if (last_i) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (BCNT_W'(k) > cnt_q) word_ins[k*BYTE_W +: BYTE_W] = '0;
      end
    end
  end

  assign done_o = push_i && ((cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) || last_i);
  assign word_o = word_ins;

  // The word is handed off on the completing push, so the register restarts empty.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (push_i) begin
      if (done_o) begin
        cnt_d  = '0;
        word_d = '0;
      end else begin
        cnt_d  = cnt_q + BCNT_W'(1);
        word_d = word_ins;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory one word at a time, then starts the CPU.
//   state | meaning
//   IDLE  | after reset, waiting for the first byte
//   LOAD  | collecting bytes of the current word
//   WRITE | one-cycle write strobe for the packed word
//   DONE  | image loaded, CPU start held high
//   ERROR | image larger than the memory, loading halted
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_data_i,
  input  logic              last_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [31:0]       wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  output logic              start_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

  ldr_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              last_q, last_d;

  logic              full;
  logic              xfer;
  logic              word_done;
  logic [WORD_W-1:0] packed_word;

  // A full memory refuses further bytes so that an overflowing byte is never consumed.
  assign full         = (idx_q == IDX_W'(DEPTH_WORDS));
  assign byte_ready_o = (state_q == ST_IDLE) || ((state_q == ST_LOAD) && !full);
  assign xfer         = byte_valid_i && byte_ready_o;

  byte_packer u_packer (
    .clk_i  (clk_i),
    .clr_i  (rst_i),
    .push_i (xfer),
    .byte_i (byte_data_i),
    .last_i (last_i),
    .word_o (packed_word),
    .done_o (word_done)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (xfer) begin
          if (word_done) begin
            state_d   = ST_WRITE;
            wr_addr_d = BASE_ADDR + (32'(idx_q) << 2);
            wr_data_d = packed_word;
            last_d    = last_i;
          end else begin
            state_d = ST_LOAD;
          end
        end else if ((state_q == ST_LOAD) && full && byte_valid_i) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = last_q ? ST_DONE : ST_LOAD;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
    end
  end

  assign wr_en_o   = (state_q == ST_WRITE);
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign start_o   = (state_q == ST_DONE);
  assign err_o     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized image streaming against a word-level reference model, on three
// loader configurations (default, 2-word memory, base address 0x100).
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       last = 1'b0;
  int         sel = 0;

  logic        v     [3];
  logic        rdy   [3];
  logic        wen   [3];
  logic [31:0] waddr [3];
  logic [31:0] wdata [3];
  logic        strt  [3];
  logic        errs  [3];

  always #5 clk = ~clk;

  assign v[0] = valid && (sel == 0);
  assign v[1] = valid && (sel == 1);
  assign v[2] = valid && (sel == 2);

  imem_loader dut0 (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(v[0]), .byte_data_i(data), .last_i(last),
    .byte_ready_o(rdy[0]), .wr_en_o(wen[0]), .wr_addr_o(waddr[0]), .wr_data_o(wdata[0]),
    .start_o(strt[0]), .err_o(errs[0]));

  imem_loader #(.DEPTH_WORDS(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(v[1]), .byte_data_i(data), .last_i(last),
    .byte_ready_o(rdy[1]), .wr_en_o(wen[1]), .wr_addr_o(waddr[1]), .wr_data_o(wdata[1]),
    .start_o(strt[1]), .err_o(errs[1]));

  imem_loader #(.BASE_ADDR(32'h100)) dut2 (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(v[2]), .byte_data_i(data), .last_i(last),
    .byte_ready_o(rdy[2]), .wr_en_o(wen[2]), .wr_addr_o(waddr[2]), .wr_data_o(wdata[2]),
    .start_o(strt[2]), .err_o(errs[2]));

  logic        s_rdy, s_wen, s_start, s_err;
  logic [31:0] s_waddr, s_wdata;
  assign s_rdy   = rdy[sel];
  assign s_wen   = wen[sel];
  assign s_waddr = waddr[sel];
  assign s_wdata = wdata[sel];
  assign s_start = strt[sel];
  assign s_err   = errs[sel];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          rdy_viol = 0;

  always @(negedge clk) begin
    if (!rst && s_wen) begin
      got_addr.push_back(s_waddr);
      got_data.push_back(s_wdata);
      if (s_rdy) rdy_viol++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
    rdy_viol = 0;
  endtask

  // Offers the image byte by byte; gives up on a byte after a bounded wait.
  task automatic send_image(input logic [7:0] img[$], input bit last_at_end,
                            input int gap_pct, output int accepted);
    int bw = 0;
    bit pend = 0;
    accepted = 0;
    for (int i = 0; i < img.size(); i++) begin
      bit done = 0;
      int waited = 0;
      while (!done && waited < 60) begin
        @(negedge clk);
        if (pend) begin chk("wr_latency", 32'(s_wen), 32'd1); pend = 0; end
        if (int'($urandom_range(0, 99)) < gap_pct) begin
          valid = 1'b0; data = 8'($urandom); last = 1'($urandom);
        end else begin
          valid = 1'b1; data = img[i]; last = last_at_end && (i == img.size() - 1);
          if (s_rdy) begin
            done = 1; accepted++;
            if (bw == 3 || last) begin pend = 1; bw = 0; end else bw++;
          end
        end
        waited++;
      end
      if (!done) break;
    end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    if (pend) chk("wr_latency", 32'(s_wen), 32'd1);
  endtask

  // Reference: image split into little-endian words, truncated at the memory depth.
  task automatic model(input logic [7:0] img[$], input logic [31:0] base, input int depth,
                       output logic [31:0] ea[$], output logic [31:0] ed[$],
                       output int eacc, output bit estart, output bit eerr);
    int nwords = (img.size() + 3) / 4;
    int nw;
    ea.delete(); ed.delete();
    estart = (nwords <= depth);
    eerr   = !estart;
    nw     = estart ? nwords : depth;
    eacc   = estart ? img.size() : depth * 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * w + j < img.size()) word = word | (32'(img[4 * w + j]) << (8 * j));
      ea.push_back(base + 32'(4 * w));
      ed.push_back(word);
    end
  endtask

  task automatic run(input string name, input int s, input logic [7:0] img[$],
                     input int gap_pct, input bit with_reset);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    int eacc, acc, wt;
    bit estart, eerr;
    logic [31:0] base;
    int depth;
    base  = (s == 2) ? 32'h100 : 32'h0;
    depth = (s == 1) ? 2 : 256;
    sel   = s;
    if (with_reset) do_reset();
    model(img, base, depth, ea, ed, eacc, estart, eerr);
    send_image(img, 1'b1, gap_pct, acc);
    wt = 0;
    while (!(s_start || s_err) && wt < 30) begin @(negedge clk); wt++; end
    chk({name, ":accepted"}, 32'(acc), 32'(eacc));
    chk({name, ":n_writes"}, 32'(got_addr.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
      chk($sformatf("%s:addr%0d", name, i), got_addr[i], ea[i]);
      chk($sformatf("%s:data%0d", name, i), got_data[i], ed[i]);
    end
    chk({name, ":start"}, 32'(s_start), 32'(estart));
    chk({name, ":err"}, 32'(s_err), 32'(eerr));
    chk({name, ":ready_in_write"}, 32'(rdy_viol), 32'd0);
  endtask

  initial begin
    logic [7:0] img[$];
    int acc;

    do_reset();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst%0d:ready", s), 32'(rdy[s]), 32'd1);
      chk($sformatf("rst%0d:wr_en", s), 32'(wen[s]), 32'd0);
      chk($sformatf("rst%0d:addr", s), waddr[s], (s == 2) ? 32'h100 : 32'h0);
      chk($sformatf("rst%0d:data", s), wdata[s], 32'h0);
      chk($sformatf("rst%0d:start", s), 32'(strt[s]), 32'd0);
      chk($sformatf("rst%0d:err", s), 32'(errs[s]), 32'd0);
    end

    img = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    run("two_words", 0, img, 0, 1);
    chk("two_words:data0_const", got_data.size() > 0 ? got_data[0] : 32'hX, 32'h0050_0013);

    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run("zero_fill", 0, img, 0, 1);

    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    run("overflow", 1, img, 0, 1);

    for (int it = 0; it < 8; it++) begin
      int n = int'($urandom_range(1, 14));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      run($sformatf("rand%0d", it), (it % 4 == 3) ? 1 : 0, img, 45, 1);
    end

    // Reset mid-word: the two pending bytes must vanish.
    sel = 0;
    do_reset();
    img = '{8'h01, 8'h02};
    send_image(img, 1'b0, 0, acc);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst:no_write", 32'(got_addr.size()), 32'd0);
    chk("midrst:start", 32'(s_start), 32'd0);
    chk("midrst:ready", 32'(s_rdy), 32'd1);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run("after_rst", 0, img, 0, 0);

    img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run("base100", 2, img, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = 1'b1; data = 8'($urandom); last = 1'($urandom);
      if (i == 5) chk("done:ready", 32'(s_rdy), 32'd0);
    end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    chk("done:no_more_writes", 32'(got_addr.size()), 32'd1);
    chk("done:start_held", 32'(s_start), 32'd1);
    chk("done:addr_held", s_waddr, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
